music_playback_ctrl: RTL
========================

Name: music_playback_ctrl

Overview:
Sequences playback of the music sample ROM into the audio codec path. It generates the sample-rate tick from CLOCK_50 and walks the ROM address space. It waits out ROM read latency, then pushes each sample into the Audio_Controller write interface using the audio_out_allowed / write_audio_out handshake. It sits between the user controls (start/pause/stop), the music ROM and Audio_Controller, and replaces the free-running address counter and 16 kHz divider.

Parameters:
ADDR_W, 17, ROM address width
DATA_W, 16, ROM sample width (signed two's complement)
SAMPLE_DIV, 3125, CLOCK_50 cycles per sample (50 MHz / 16 kHz)
LAST_ADDR, 17'd99999, final sample address of the tune
ROM_LAT, 2, CLOCK_50 cycles from rom_addr change to valid rom_q

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
start  in  1  level; rising edge starts playback from address 0
pause  in  1  level; holds playback at current sample
stop  in  1  level; aborts playback, returns to idle
loop_en  in  1  1 = wrap to address 0 after LAST_ADDR
rom_addr  out  ADDR_W  ROM address
rom_q  in  DATA_W  ROM data
audio_out_allowed  in  1  Audio_Controller output FIFO has space
write_audio_out  out  1  one-cycle write strobe to Audio_Controller
left_channel_audio_out  out  32  left sample, {sample, 16'b0}
right_channel_audio_out  out  32  right sample, identical to left
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on natural end of tune (loop_en=0)
underrun  out  1  sticky; set when a sample could not be pushed before its tick

Behaviour:
- Reset (synchronous, active-high): state=IDLE; rom_addr=0; tick counter=0; sample register=0; start_d=0.
  - All outputs 0 on reset: write_audio_out, both channel outputs, busy, done, underrun.
- start edge detection: start_rise = start & ~start_d, where start_d is registered every cycle.
- stop has priority over everything except reset.
  - stop=1 in any state: next state is IDLE, rom_addr=0, tick counter=0, no done pulse, underrun preserved.
- Tick counter runs 0..SAMPLE_DIV-1 and then wraps to 0.
  - tick=1 in the cycle the count equals SAMPLE_DIV-1.
  - Counter is held at 0 in IDLE and frozen while pause=1.
- States:
  - IDLE: start_rise and not stop -> FETCH; rom_addr=0; tick counter cleared; underrun cleared.
  - FETCH: latency counter counts ROM_LAT cycles. On expiry, rom_q is captured into the sample register -> PUSH. rom_addr is stable throughout.
  - PUSH:
    - audio_out_allowed=1: write_audio_out=1 for exactly one cycle; channel outputs carry {sample, 16'b0} in that cycle and are held afterwards -> WAIT_TICK.
    - tick occurs while still in PUSH (allowed never seen): sample dropped, underrun<=1, advance as in WAIT_TICK.
  - WAIT_TICK:
    - On tick with pause=0: if rom_addr==LAST_ADDR, then loop_en=1 -> rom_addr=0, FETCH; loop_en=0 -> done=1 for one cycle, IDLE.
    - Otherwise rom_addr+1 -> FETCH.
    - pause=1: remain in WAIT_TICK; outputs unchanged.
- Pause is sampled only in WAIT_TICK. A pause asserted during FETCH or PUSH takes effect after the current push.
- start_rise while busy is ignored.
- The first sample is pushed ROM_LAT+1 cycles after start_rise. Consecutive writes are exactly SAMPLE_DIV cycles apart when audio_out_allowed stays high.
- rom_addr never exceeds LAST_ADDR. The address increment wraps only via the loop_en path.

Optional Feature:
MUSIC_VOLUME_EN:
- Defined: adds input volume[2:0]. The pushed sample is sample >>> volume (arithmetic shift, sign preserved) before left-justifying. volume is sampled in the capture cycle.
- Undefined: no volume port; sample passes unmodified.

Decomposition:
- Package music_pkg: state enum (IDLE, FETCH, PUSH, WAIT_TICK), ADDR_W/DATA_W defaults, sample-to-channel packing function.
- Sub-module sample_tick_gen: parameter SAMPLE_DIV; inputs CLOCK_50, reset, clear, freeze; output tick. Reused wherever the 16 kHz enable is needed.

Test Plan:
All scenarios use SAMPLE_DIV=8, ROM_LAT=2, LAST_ADDR=3, rom_q=addr+16'h0100.
- Basic play: pulse start at cycle 10, loop_en=0, allowed=1.
  - First write at cycle 13 with left=32'h0100_0000.
  - Writes every 8 cycles for addresses 0..3.
  - done pulses once on the tick after address 3; busy drops next cycle.
- Loop: loop_en=1, 10 writes.
  - Address sequence 0,1,2,3,0,1,2,3,0,1; done never asserted.
- Backpressure: allowed=0 for 3 cycles after capture of address 1 -> write delayed 3 cycles, no underrun.
  - allowed=0 through the whole period -> address 1 dropped, underrun=1, next write carries 32'h0102_0000.
- Pause: pause=1 during WAIT_TICK after address 1 for 20 cycles -> no writes, rom_addr stays 1; resumes with address 2 eight cycles after release.
- Stop mid-FETCH plus restart: stop -> IDLE next cycle, rom_addr=0, no done. New start_rise -> first write carries address 0. start while busy -> ignored.
- Reset mid-PUSH: all outputs 0 the cycle after reset; underrun cleared.
  - With MUSIC_VOLUME_EN, volume=2 and rom_q=16'h8000 -> left=32'hE000_0000.

Source files
------------

// File: rtl/music_pkg.sv
// music_pkg: shared state type, width defaults and channel packing for music playback
package music_pkg;
  localparam int DEF_ADDR_W = 17;
  localparam int DEF_DATA_W = 16;
  typedef enum logic [1:0] {IDLE, FETCH, PUSH, WAIT_TICK} state_t;
  function automatic logic [31:0] pack_sample(input logic [DEF_DATA_W-1:0] s);
    return {s, {(32-DEF_DATA_W){1'b0}}};
  endfunction
endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: one-cycle tick every SAMPLE_DIV clocks, clearable and freezable
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 3125
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  input  logic freeze,
  output logic tick
);
  localparam int CW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(SAMPLE_DIV - 1);
  always_ff @(posedge CLOCK_50)
    if (reset || clear) cnt <= '0;
    else if (!freeze) cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/music_playback_ctrl.sv
// music_playback_ctrl: sequences music ROM samples into Audio_Controller; define MUSIC_VOLUME_EN for a volume shift input
module music_playback_ctrl
  import music_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                SAMPLE_DIV = 3125,
  parameter logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(99999),
  parameter int                ROM_LAT    = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
`ifdef MUSIC_VOLUME_EN
  input  logic [2:0]        volume,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  input  logic              audio_out_allowed,
  output logic              write_audio_out,
  output logic [31:0]       left_channel_audio_out,
  output logic [31:0]       right_channel_audio_out,
  output logic              busy,
  output logic              done,
  output logic              underrun
);
  localparam int LW = ROM_LAT > 1 ? $clog2(ROM_LAT) : 1;
  state_t state, next_state;
  logic start_d, start_rise, tick, at_last, adv, fetch_done;
  logic [LW-1:0] lat_cnt;
  logic [DATA_W-1:0] sample, out_sample, shaped;
  assign start_rise = start & ~start_d;
  assign at_last = rom_addr == LAST_ADDR;
  assign fetch_done = state == FETCH && lat_cnt == LW'(ROM_LAT - 1);
  // a tick caught in PUSH moves on regardless of pause: the sample is written this cycle or lost
  assign adv = !stop && tick && (state == PUSH || (state == WAIT_TICK && !pause));
`ifdef MUSIC_VOLUME_EN
  assign shaped = $signed(rom_q) >>> volume;
`else
  assign shaped = rom_q;
`endif
  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .clear(state == IDLE || stop),
    .freeze(pause),
    .tick(tick)
  );
  always_ff @(posedge CLOCK_50) state <= reset ? IDLE : next_state;
  always_comb
    next_state = stop ? IDLE
      : adv ? (at_last && !loop_en ? IDLE : FETCH)
      : state == IDLE && start_rise ? FETCH
      : fetch_done ? PUSH
      : state == PUSH && audio_out_allowed ? WAIT_TICK
      : state;
  always_comb begin
    write_audio_out = state == PUSH && audio_out_allowed && !stop;
    done = adv && at_last && !loop_en;
    busy = state != IDLE;
    left_channel_audio_out = pack_sample(write_audio_out ? sample : out_sample);
    right_channel_audio_out = left_channel_audio_out;
  end
  always_ff @(posedge CLOCK_50)
    if (reset) begin
      rom_addr <= '0;
      lat_cnt <= '0;
      sample <= '0;
      out_sample <= '0;
      start_d <= 1'b0;
      underrun <= 1'b0;
    end else begin
      start_d <= start;
      lat_cnt <= fetch_done || state != FETCH ? '0 : lat_cnt + LW'(1);
      rom_addr <= stop || state == IDLE || (adv && at_last) ? '0 : adv ? rom_addr + ADDR_W'(1) : rom_addr;
      if (fetch_done) sample <= shaped;
      if (write_audio_out) out_sample <= sample;
      underrun <= state == IDLE && start_rise && !stop ? 1'b0
        : state == PUSH && tick && !audio_out_allowed && !stop ? 1'b1
        : underrun;
    end
endmodule
